// File: rtl/qpu_exu_evt_tq.sv
// Event timing queue: tags events written back by the ALU with the current
// time point and releases them in order once the system timer reaches the tag.
module qpu_exu_evt_tq #(
  parameter int unsigned TIME_W  = 32,
  parameter int unsigned EVT_W   = 24,
  parameter int unsigned EVT_NUM = 8,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       twbck_i_valid,
  output logic                       twbck_i_ready,
  input  logic [TIME_W-1:0]          twbck_i_data,
  input  logic                       ewbck_i_valid,
  output logic                       ewbck_i_ready,
  input  logic [EVT_W-1:0]           ewbck_i_data,
  input  logic [EVT_NUM-1:0]         ewbck_i_oprand,
  input  logic                       tmr_en,
  input  logic                       flush,
  output logic                       evt_o_valid,
  input  logic                       evt_o_ready,
  output logic [EVT_W-1:0]           evt_o_data,
  output logic [EVT_NUM-1:0]         evt_o_oprand,
  output logic [TIME_W-1:0]          evt_o_time,
  output logic                       evt_o_late,
  output logic [TIME_W-1:0]          sys_time,
  output logic [$clog2(DEPTH):0]     tq_count,
  output logic                       tq_full,
  output logic                       tq_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [EVT_W-1:0]   data;
    logic [EVT_NUM-1:0] oprand;
    logic [TIME_W-1:0]  tag;
  } tq_entry_t;

  tq_entry_t          mem [DEPTH];
  logic [TIME_W-1:0]  sys_time_q;
  logic [TIME_W-1:0]  tp_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic               full_c;
  logic               empty_c;
  logic               push_c;
  logic               pop_c;
  logic               tw_fire_c;
  logic               due_c;
  logic [TIME_W-1:0]  diff_c;
  tq_entry_t          head_c;
  tq_entry_t          new_entry_c;

  // Occupancy flags from registered count only
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == CNT_W'(0));

  // Readies: a joint time+event write is taken atomically; flush blocks both
  assign ewbck_i_ready = ~full_c & ~flush;
  assign twbck_i_ready = ~flush & (ewbck_i_valid ? ~full_c : 1'b1);

  assign tw_fire_c = twbck_i_valid & twbck_i_ready;
  assign push_c    = ewbck_i_valid & ewbck_i_ready;
  assign pop_c     = evt_o_valid & evt_o_ready;

  // Incoming event is tagged with a same-cycle time point when one arrives
  always_comb begin
    new_entry_c        = '0;
    new_entry_c.data   = ewbck_i_data;
    new_entry_c.oprand = ewbck_i_oprand;
    new_entry_c.tag    = tw_fire_c ? twbck_i_data : tp_q;
  end

  // Head due test over a half-range window so timer wrap is handled
  assign head_c = mem[rd_ptr_q];
  assign diff_c = sys_time_q - head_c.tag;
  assign due_c  = ~diff_c[TIME_W-1];

  assign evt_o_valid  = ~empty_c & due_c & ~flush;
  assign evt_o_late   = evt_o_valid & (diff_c != '0);
  assign evt_o_data   = empty_c ? '0 : head_c.data;
  assign evt_o_oprand = empty_c ? '0 : head_c.oprand;
  assign evt_o_time   = empty_c ? '0 : head_c.tag;

  assign sys_time = sys_time_q;
  assign tq_count = count_q;
  assign tq_full  = full_c;
  assign tq_empty = empty_c;

  // Free-running system timer, unaffected by flush and writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_time_q <= '0;
    end else if (tmr_en) begin
      sys_time_q <= sys_time_q + TIME_W'(1);
    end
  end

  // Absolute time point register, overwritten on each accepted time write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q <= '0;
    end else if (tw_fire_c) begin
      tp_q <= twbck_i_data;
    end
  end

  // Queue storage; contents are only visible while the entry is occupied
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= new_entry_c;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
